// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit
//  Description : Reorder buffer. Allocates one entry per dispatched
//                instruction, absorbs functional-unit writebacks, serves
//                two operand look-ups with writeback bypass, and retires
//                completed entries strictly in program order to the
//                regfile commit port.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_commit #(
    parameter  int ROB_SIZE     = 18,
    parameter  int REG_SIZE     = 64,
    parameter  int GPR_IDX_SIZE = 5,
    localparam int IDX          = $clog2(ROB_SIZE)
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic                    in_alloc_valid,
    input  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx,
    input  logic                    in_alloc_set_nzcv,
    output logic                    out_alloc_ready,
    output logic [IDX-1:0]          out_alloc_rob_index,
    input  logic                    in_wb_valid,
    input  logic [IDX-1:0]          in_wb_rob_index,
    input  logic [REG_SIZE-1:0]     in_wb_value,
    input  logic [3:0]              in_wb_nzcv,
    input  logic [IDX-1:0]          in_rd1_rob_index,
    input  logic [IDX-1:0]          in_rd2_rob_index,
    output logic                    out_rd1_ready,
    output logic                    out_rd2_ready,
    output logic [REG_SIZE-1:0]     out_rd1_value,
    output logic [REG_SIZE-1:0]     out_rd2_value,
    output logic                    out_commit_valid,
    output logic [IDX-1:0]          out_commit_rob_index,
    output logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx,
    output logic [REG_SIZE-1:0]     out_commit_value,
    output logic                    out_commit_set_nzcv,
    output logic [3:0]              out_commit_nzcv,
    output logic [IDX:0]            out_count
);

    localparam logic [IDX-1:0] LAST_IDX = IDX'(ROB_SIZE - 1);
    localparam logic [IDX:0]   CNT_FULL = (IDX + 1)'(ROB_SIZE);

    // Per-entry state: control bits are reset, payload is not
    logic [ROB_SIZE-1:0]     valid_q;
    logic [ROB_SIZE-1:0]     done_q;
    logic [GPR_IDX_SIZE-1:0] gpr_q   [ROB_SIZE];
    logic                    setn_q  [ROB_SIZE];
    logic [REG_SIZE-1:0]     value_q [ROB_SIZE];
    logic [3:0]              nzcv_q  [ROB_SIZE];

    logic [IDX-1:0] head_q, head_d;
    logic [IDX-1:0] tail_q, tail_d;
    logic [IDX:0]   count_q, count_d;

    logic                    cvalid_q;
    logic [IDX-1:0]          crob_q;
    logic [GPR_IDX_SIZE-1:0] cgpr_q;
    logic [REG_SIZE-1:0]     cvalue_q;
    logic                    cset_q;
    logic [3:0]              cnzcv_q;

    logic w_alloc_fire;
    logic w_commit_fire;

    // Pointer advance with explicit wrap, since ROB_SIZE need not be 2^n
    function automatic logic [IDX-1:0] inc_wrap(input logic [IDX-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Operand look-up: a same-cycle writeback to a live entry is bypassed
    function automatic logic [REG_SIZE:0] lookup(input logic [IDX-1:0] idx);
        logic live;
        live = (idx <= LAST_IDX) && valid_q[idx];
        if (live && in_wb_valid && (in_wb_rob_index == idx))
            return {1'b1, in_wb_value};
        else if (live)
            return {done_q[idx], value_q[idx]};
        else
            return '0;
    endfunction

    // Fire conditions; fullness looks only at the registered count
    always_comb begin
        out_alloc_ready = (count_q != CNT_FULL);
        w_alloc_fire    = in_alloc_valid && out_alloc_ready;
        w_commit_fire   = valid_q[head_q] && done_q[head_q];
    end

    // Next pointer and occupancy values
    always_comb begin
        head_d  = w_commit_fire ? inc_wrap(head_q) : head_q;
        tail_d  = w_alloc_fire ? inc_wrap(tail_q) : tail_q;
        count_d = count_q;
        if (w_alloc_fire && !w_commit_fire)
            count_d = count_q + 1'b1;
        else if (!w_alloc_fire && w_commit_fire)
            count_d = count_q - 1'b1;
    end

    // Control state, pointers and commit port registers
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            done_q   <= '0;
            cvalid_q <= 1'b0;
            crob_q   <= '0;
            cgpr_q   <= '0;
            cvalue_q <= '0;
            cset_q   <= 1'b0;
            cnzcv_q  <= '0;
        end else if (in_flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            done_q   <= '0;
            cvalid_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cvalid_q <= w_commit_fire;
            if (w_commit_fire) begin
                crob_q   <= head_q;
                cgpr_q   <= gpr_q[head_q];
                cvalue_q <= value_q[head_q];
                cset_q   <= setn_q[head_q];
                cnzcv_q  <= nzcv_q[head_q];
            end
            // Allocation beats a colliding writeback; commit retires the head
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (w_alloc_fire && (tail_q == IDX'(i))) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                end else if (w_commit_fire && (head_q == IDX'(i))) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end else if (in_wb_valid && (in_wb_rob_index == IDX'(i)) && valid_q[i]) begin
                    done_q[i]  <= 1'b1;
                end
            end
        end
    end

    // Entry payload; writes are dropped on reset/flush cycles
    always_ff @(posedge in_clk) begin
        if (!in_rst && !in_flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (w_alloc_fire && (tail_q == IDX'(i))) begin
                    gpr_q[i]  <= in_alloc_gpr_idx;
                    setn_q[i] <= in_alloc_set_nzcv;
                end else if (in_wb_valid && (in_wb_rob_index == IDX'(i)) && valid_q[i]) begin
                    value_q[i] <= in_wb_value;
                    nzcv_q[i]  <= in_wb_nzcv;
                end
            end
        end
    end

    // Combinational read ports
    always_comb begin
        {out_rd1_ready, out_rd1_value} = lookup(in_rd1_rob_index);
        {out_rd2_ready, out_rd2_value} = lookup(in_rd2_rob_index);
    end

    assign out_alloc_rob_index  = tail_q;
    assign out_count            = count_q;
    assign out_commit_valid     = cvalid_q;
    assign out_commit_rob_index = crob_q;
    assign out_commit_gpr_idx   = cgpr_q;
    assign out_commit_value     = cvalue_q;
    assign out_commit_set_nzcv  = cset_q;
    assign out_commit_nzcv      = cnzcv_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit
//  Description : Directed self-checking bench for rob_commit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rob_commit;

    logic        in_clk = 1'b0;
    logic        in_rst, in_flush;
    logic        in_alloc_valid, in_alloc_set_nzcv;
    logic [4:0]  in_alloc_gpr_idx;
    logic        out_alloc_ready;
    logic [4:0]  out_alloc_rob_index;
    logic        in_wb_valid;
    logic [4:0]  in_wb_rob_index;
    logic [63:0] in_wb_value;
    logic [3:0]  in_wb_nzcv;
    logic [4:0]  in_rd1_rob_index, in_rd2_rob_index;
    logic        out_rd1_ready, out_rd2_ready;
    logic [63:0] out_rd1_value, out_rd2_value;
    logic        out_commit_valid;
    logic [4:0]  out_commit_rob_index;
    logic [4:0]  out_commit_gpr_idx;
    logic [63:0] out_commit_value;
    logic        out_commit_set_nzcv;
    logic [3:0]  out_commit_nzcv;
    logic [5:0]  out_count;

    int errors = 0;
    int checks = 0;

    rob_commit #(.ROB_SIZE(18), .REG_SIZE(64), .GPR_IDX_SIZE(5)) dut (
        .in_clk               (in_clk),
        .in_rst               (in_rst),
        .in_flush             (in_flush),
        .in_alloc_valid       (in_alloc_valid),
        .in_alloc_gpr_idx     (in_alloc_gpr_idx),
        .in_alloc_set_nzcv    (in_alloc_set_nzcv),
        .out_alloc_ready      (out_alloc_ready),
        .out_alloc_rob_index  (out_alloc_rob_index),
        .in_wb_valid          (in_wb_valid),
        .in_wb_rob_index      (in_wb_rob_index),
        .in_wb_value          (in_wb_value),
        .in_wb_nzcv           (in_wb_nzcv),
        .in_rd1_rob_index     (in_rd1_rob_index),
        .in_rd2_rob_index     (in_rd2_rob_index),
        .out_rd1_ready        (out_rd1_ready),
        .out_rd2_ready        (out_rd2_ready),
        .out_rd1_value        (out_rd1_value),
        .out_rd2_value        (out_rd2_value),
        .out_commit_valid     (out_commit_valid),
        .out_commit_rob_index (out_commit_rob_index),
        .out_commit_gpr_idx   (out_commit_gpr_idx),
        .out_commit_value     (out_commit_value),
        .out_commit_set_nzcv  (out_commit_set_nzcv),
        .out_commit_nzcv      (out_commit_nzcv),
        .out_count            (out_count)
    );

    always #5 in_clk = ~in_clk;

    // Inputs change just after the falling edge; one call crosses one rising edge
    task automatic cycle();
        @(negedge in_clk);
    endtask

    task automatic do_alloc(input logic [4:0] gpr, input logic setn);
        in_alloc_valid    = 1'b1;
        in_alloc_gpr_idx  = gpr;
        in_alloc_set_nzcv = setn;
        cycle();
        in_alloc_valid    = 1'b0;
        in_alloc_set_nzcv = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] idx, input logic [63:0] val, input logic [3:0] nz);
        in_wb_valid     = 1'b1;
        in_wb_rob_index = idx;
        in_wb_value     = val;
        in_wb_nzcv      = nz;
        cycle();
        in_wb_valid     = 1'b0;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        cycle();
        in_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_alloc_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", out_alloc_ready); errors++; end
        checks++; if (out_alloc_rob_index !== 5'd0) begin $display("FAIL rst_alloc_idx: got %0d want 0", out_alloc_rob_index); errors++; end
        checks++; if (out_count !== 6'd0) begin $display("FAIL rst_count: got %0d want 0", out_count); errors++; end
        checks++; if (out_commit_valid !== 1'b0) begin $display("FAIL rst_commit_valid: got %b want 0", out_commit_valid); errors++; end
        checks++; if ({out_commit_rob_index, out_commit_gpr_idx, out_commit_value, out_commit_set_nzcv, out_commit_nzcv} !== '0) begin
            $display("FAIL rst_commit_fields: got idx=%0d gpr=%0d val=%h set=%b nzcv=%b want all 0",
                     out_commit_rob_index, out_commit_gpr_idx, out_commit_value, out_commit_set_nzcv, out_commit_nzcv); errors++; end
        checks++; if ({out_rd1_ready, out_rd1_value} !== '0) begin $display("FAIL rst_rd1: got ready=%b val=%h want 0/0", out_rd1_ready, out_rd1_value); errors++; end
        cycle();
    endtask

    task automatic test_alloc_commit();
        for (int i = 0; i < 3; i++) begin
            in_alloc_valid   = 1'b1;
            in_alloc_gpr_idx = 5'(i + 1);
            #1;
            checks++; if (out_alloc_rob_index !== 5'(i)) begin $display("FAIL alloc_idx%0d: got %0d want %0d", i, out_alloc_rob_index, i); errors++; end
            cycle();
        end
        in_alloc_valid = 1'b0;
        checks++; if (out_count !== 6'd3) begin $display("FAIL count3: got %0d want 3", out_count); errors++; end
        do_wb(5'd0, 64'hA, 4'd0);
        checks++; if (out_commit_valid !== 1'b0) begin $display("FAIL wb_latency1: got %b want 0", out_commit_valid); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b1) begin $display("FAIL commit0_valid: got %b want 1", out_commit_valid); errors++; end
        checks++; if (out_commit_gpr_idx !== 5'd1 || out_commit_value !== 64'hA || out_commit_rob_index !== 5'd0) begin
            $display("FAIL commit0_data: got gpr=%0d val=%h idx=%0d want 1/a/0", out_commit_gpr_idx, out_commit_value, out_commit_rob_index); errors++; end
        checks++; if (out_count !== 6'd2) begin $display("FAIL count2: got %0d want 2", out_count); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b0 || out_commit_gpr_idx !== 5'd1 || out_commit_value !== 64'hA) begin
            $display("FAIL commit_hold: got v=%b gpr=%0d val=%h want 0/1/a", out_commit_valid, out_commit_gpr_idx, out_commit_value); errors++; end
    endtask

    task automatic test_back_to_back();
        do_wb(5'd2, 64'h22, 4'd0);
        checks++; if (out_commit_valid !== 1'b0) begin $display("FAIL ooo_wait1: got %b want 0", out_commit_valid); errors++; end
        do_wb(5'd1, 64'h11, 4'd0);
        checks++; if (out_commit_valid !== 1'b0) begin $display("FAIL ooo_wait2: got %b want 0", out_commit_valid); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b1 || out_commit_gpr_idx !== 5'd2 || out_commit_value !== 64'h11) begin
            $display("FAIL b2b_first: got v=%b gpr=%0d val=%h want 1/2/11", out_commit_valid, out_commit_gpr_idx, out_commit_value); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b1 || out_commit_gpr_idx !== 5'd3 || out_commit_value !== 64'h22) begin
            $display("FAIL b2b_second: got v=%b gpr=%0d val=%h want 1/3/22", out_commit_valid, out_commit_gpr_idx, out_commit_value); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b0 || out_count !== 6'd0) begin
            $display("FAIL b2b_drain: got v=%b count=%0d want 0/0", out_commit_valid, out_count); errors++; end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in_alloc_valid   = 1'b1;
            in_alloc_gpr_idx = 5'(i);
            #1;
            checks++; if (out_alloc_rob_index !== 5'(i)) begin $display("FAIL fill_idx%0d: got %0d want %0d", i, out_alloc_rob_index, i); errors++; end
            cycle();
        end
        in_alloc_valid = 1'b0;
        checks++; if (out_alloc_ready !== 1'b0 || out_count !== 6'd18) begin
            $display("FAIL full: got ready=%b count=%0d want 0/18", out_alloc_ready, out_count); errors++; end
        do_alloc(5'd30, 1'b0);
        checks++; if (out_count !== 6'd18 || out_alloc_rob_index !== 5'd0) begin
            $display("FAIL full_refuse: got count=%0d tail=%0d want 18/0", out_count, out_alloc_rob_index); errors++; end
        do_wb(5'd0, 64'h5, 4'd0);
        do_alloc(5'd29, 1'b0);
        checks++; if (out_commit_valid !== 1'b1 || out_count !== 6'd17 || out_alloc_ready !== 1'b1 || out_alloc_rob_index !== 5'd0) begin
            $display("FAIL full_commit: got v=%b count=%0d ready=%b tail=%0d want 1/17/1/0",
                     out_commit_valid, out_count, out_alloc_ready, out_alloc_rob_index); errors++; end
        in_alloc_valid   = 1'b1;
        in_alloc_gpr_idx = 5'd7;
        #1;
        checks++; if (out_alloc_rob_index !== 5'd0) begin $display("FAIL wrap_idx: got %0d want 0", out_alloc_rob_index); errors++; end
        cycle();
        in_alloc_valid = 1'b0;
        checks++; if (out_count !== 6'd18 || out_alloc_rob_index !== 5'd1) begin
            $display("FAIL wrap_after: got count=%0d tail=%0d want 18/1", out_count, out_alloc_rob_index); errors++; end
    endtask

    task automatic test_read_bypass();
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(5'(i), 1'b0);
        in_rd1_rob_index = 5'd5;
        in_rd2_rob_index = 5'd7;
        #1;
        checks++; if (out_rd1_ready !== 1'b0) begin $display("FAIL rd_pending: got %b want 0", out_rd1_ready); errors++; end
        in_wb_valid = 1'b1; in_wb_rob_index = 5'd5; in_wb_value = 64'h55; in_wb_nzcv = 4'd0;
        #1;
        checks++; if (out_rd1_ready !== 1'b1 || out_rd1_value !== 64'h55) begin
            $display("FAIL rd_bypass: got ready=%b val=%h want 1/55", out_rd1_ready, out_rd1_value); errors++; end
        checks++; if (out_rd2_ready !== 1'b0 || out_rd2_value !== 64'h0) begin
            $display("FAIL rd_empty: got ready=%b val=%h want 0/0", out_rd2_ready, out_rd2_value); errors++; end
        cycle();
        in_wb_valid = 1'b0;
        #1;
        checks++; if (out_rd1_ready !== 1'b1 || out_rd1_value !== 64'h55) begin
            $display("FAIL rd_stored: got ready=%b val=%h want 1/55", out_rd1_ready, out_rd1_value); errors++; end
        in_rd2_rob_index = 5'd9;
        in_wb_valid = 1'b1; in_wb_rob_index = 5'd9; in_wb_value = 64'h99;
        #1;
        checks++; if (out_rd2_ready !== 1'b0 || out_rd2_value !== 64'h0) begin
            $display("FAIL rd_wb_invalid: got ready=%b val=%h want 0/0", out_rd2_ready, out_rd2_value); errors++; end
        cycle();
        in_wb_valid = 1'b0;
        #1;
        checks++; if (out_rd2_ready !== 1'b0 || out_count !== 6'd6) begin
            $display("FAIL wb_invalid_ignored: got ready=%b count=%0d want 0/6", out_rd2_ready, out_count); errors++; end
    endtask

    task automatic test_nzcv();
        do_reset();
        do_alloc(5'd4, 1'b1);
        do_wb(5'd0, 64'h77, 4'b0110);
        cycle();
        checks++; if (out_commit_valid !== 1'b1 || out_commit_set_nzcv !== 1'b1 || out_commit_nzcv !== 4'b0110
                      || out_commit_gpr_idx !== 5'd4 || out_commit_value !== 64'h77) begin
            $display("FAIL nzcv_commit: got v=%b set=%b nzcv=%b gpr=%0d val=%h want 1/1/0110/4/77",
                     out_commit_valid, out_commit_set_nzcv, out_commit_nzcv, out_commit_gpr_idx, out_commit_value); errors++; end
        cycle();
    endtask

    task automatic test_flush();
        // head=tail=1 here, commit fields still hold the nzcv entry
        for (int i = 0; i < 5; i++) do_alloc(5'(10 + i), 1'b0);
        do_wb(5'd1, 64'h1111, 4'd0);
        in_flush = 1'b1;
        do_wb(5'd2, 64'h2222, 4'd0);
        in_flush = 1'b0;
        checks++; if (out_count !== 6'd0 || out_alloc_rob_index !== 5'd0 || out_commit_valid !== 1'b0) begin
            $display("FAIL flush_ptrs: got count=%0d tail=%0d v=%b want 0/0/0", out_count, out_alloc_rob_index, out_commit_valid); errors++; end
        checks++; if (out_commit_gpr_idx !== 5'd4 || out_commit_value !== 64'h77 || out_commit_nzcv !== 4'b0110 || out_commit_set_nzcv !== 1'b1) begin
            $display("FAIL flush_keep: got gpr=%0d val=%h nzcv=%b set=%b want 4/77/0110/1",
                     out_commit_gpr_idx, out_commit_value, out_commit_nzcv, out_commit_set_nzcv); errors++; end
        in_rd1_rob_index = 5'd2;
        cycle();
        checks++; if (out_commit_valid !== 1'b0 || out_rd1_ready !== 1'b0) begin
            $display("FAIL flush_quiet: got v=%b rd1=%b want 0/0", out_commit_valid, out_rd1_ready); errors++; end
        in_alloc_valid = 1'b1; in_alloc_gpr_idx = 5'd9;
        #1;
        checks++; if (out_alloc_rob_index !== 5'd0) begin $display("FAIL flush_alloc: got %0d want 0", out_alloc_rob_index); errors++; end
        cycle();
        in_alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) do_alloc(5'(20 + i), 1'b0);
        checks++; if (out_count !== 6'd5) begin $display("FAIL pre_rst_count: got %0d want 5", out_count); errors++; end
        do_wb(5'd0, 64'h3333, 4'd0);
        in_rst = 1'b1;
        do_wb(5'd1, 64'h4444, 4'd0);
        in_rst = 1'b0;
        checks++; if (out_count !== 6'd0 || out_alloc_rob_index !== 5'd0 || out_commit_valid !== 1'b0) begin
            $display("FAIL rst2_ptrs: got count=%0d tail=%0d v=%b want 0/0/0", out_count, out_alloc_rob_index, out_commit_valid); errors++; end
        checks++; if ({out_commit_rob_index, out_commit_gpr_idx, out_commit_value, out_commit_set_nzcv, out_commit_nzcv} !== '0) begin
            $display("FAIL rst2_fields: got gpr=%0d val=%h set=%b nzcv=%b want all 0",
                     out_commit_gpr_idx, out_commit_value, out_commit_set_nzcv, out_commit_nzcv); errors++; end
        cycle();
        checks++; if (out_commit_valid !== 1'b0 || out_count !== 6'd0) begin
            $display("FAIL rst2_quiet: got v=%b count=%0d want 0/0", out_commit_valid, out_count); errors++; end
    endtask

    initial begin
        in_rst = 1'b1; in_flush = 1'b0;
        in_alloc_valid = 1'b0; in_alloc_gpr_idx = '0; in_alloc_set_nzcv = 1'b0;
        in_wb_valid = 1'b0; in_wb_rob_index = '0; in_wb_value = '0; in_wb_nzcv = '0;
        in_rd1_rob_index = '0; in_rd2_rob_index = '0;
        cycle();
        test_reset();
        test_alloc_commit();
        test_back_to_back();
        test_full_wrap();
        test_read_bypass();
        test_nzcv();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
